// File: rtl/mvm8_driver.sv
`default_nettype none
// ============================================================================
// mvm8_driver : host-loaded matrix/vector buffers streamed to an MVM engine,
//               with result capture into a readable result buffer.
// Rev 1.0
// ============================================================================
module mvm8_driver #(
  parameter int WIDTH   = 12,
  parameter int N       = 8,
  parameter int MAX_VEC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [6:0]           wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 start,
  input  logic                 send_matrix,
  input  logic [2:0]           vec_count,
  input  logic [4:0]           rd_addr,
  output logic [2*WIDTH-1:0]   rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [WIDTH-1:0]     tx_data,
  output logic                 tx_new_matrix,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [2*WIDTH-1:0]   rx_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND_W = 2'd1;
  localparam logic [1:0] S_SEND_X = 2'd2;
  localparam logic [1:0] S_RECV   = 2'd3;

  localparam logic [5:0] LAST_WORD = 6'(N*N-1);
  localparam logic [2:0] VEC_LIMIT = 3'(MAX_VEC);

  logic [WIDTH-1:0]   mbuf_q [0:63];
  logic [WIDTH-1:0]   vbuf_q [0:31];
  logic [2*WIDTH-1:0] rbuf_q [0:31];

  logic [1:0]         state_q, state_d;
  logic [5:0]         word_q, word_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         vidx_q, vidx_d;
  logic [2:0]         vtot_q, vtot_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               txv_q, txv_d;
  logic               txn_q, txn_d;
  logic [WIDTH-1:0]   txd_q, txd_d;
  logic [2*WIDTH-1:0] rd_q;
  logic               w_res_we;
  logic [2:0]         w_vc;
  logic [5:0]         w_word_inc;
  logic [2:0]         w_vidx_inc;

  assign w_vc       = (vec_count > VEC_LIMIT) ? VEC_LIMIT : vec_count;
  assign w_word_inc = word_q + 6'd1;
  assign w_vidx_inc = vidx_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    row_d    = row_q;
    vidx_d   = vidx_q;
    vtot_d   = vtot_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    txv_d    = txv_q;
    txn_d    = txn_q;
    txd_d    = txd_q;
    w_res_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vtot_d = w_vc;
          word_d = 6'd0;
          row_d  = 3'd0;
          vidx_d = 3'd0;
          if (send_matrix) begin
            state_d = S_SEND_W;
            busy_d  = 1'b1;
          end else if (w_vc != 3'd0) begin
            state_d = S_SEND_X;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SEND_W: begin
        if (!txv_q) begin
          txv_d = 1'b1;
          txd_d = mbuf_q[word_q];
          txn_d = (word_q == 6'd0);
        end else if (tx_ready) begin
          txn_d = 1'b0;
          if (word_q == LAST_WORD) begin
            word_d = 6'd0;
            // Chain straight into the first vector word to keep one word per cycle.
            if (vtot_q != 3'd0) begin
              state_d = S_SEND_X;
              txd_d   = vbuf_q[{vidx_q[1:0], 3'd0}];
            end else begin
              state_d = S_IDLE;
              txv_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            word_d = w_word_inc;
            txd_d  = mbuf_q[w_word_inc];
          end
        end
      end
      S_SEND_X: begin
        if (!txv_q) begin
          txv_d = 1'b1;
          txn_d = 1'b0;
          txd_d = vbuf_q[{vidx_q[1:0], word_q[2:0]}];
        end else if (tx_ready) begin
          if (word_q[2:0] == 3'd7) begin
            state_d = S_RECV;
            txv_d   = 1'b0;
            word_d  = 6'd0;
            row_d   = 3'd0;
          end else begin
            word_d = w_word_inc;
            txd_d  = vbuf_q[{vidx_q[1:0], w_word_inc[2:0]}];
          end
        end
      end
      default: begin
        if (rx_valid) begin
          w_res_we = 1'b1;
          row_d    = row_q + 3'd1;
          if (row_q == 3'd7) begin
            row_d = 3'd0;
            if (w_vidx_inc < vtot_q) begin
              vidx_d  = w_vidx_inc;
              state_d = S_SEND_X;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      word_q  <= 6'd0;
      row_q   <= 3'd0;
      vidx_q  <= 3'd0;
      vtot_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      txv_q   <= 1'b0;
      txn_q   <= 1'b0;
      txd_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      row_q   <= row_d;
      vidx_q  <= vidx_d;
      vtot_q  <= vtot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      txv_q   <= txv_d;
      txn_q   <= txn_d;
      txd_q   <= txd_d;
      rd_q    <= rbuf_q[rd_addr];
    end
  end

  // Buffers are deliberately outside the reset domain so an abort keeps them.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      if (!wr_addr[6])
        mbuf_q[wr_addr[5:0]] <= wr_data;
      else if (!wr_addr[5])
        vbuf_q[wr_addr[4:0]] <= wr_data;
    end
    if (w_res_we)
      rbuf_q[{vidx_q[1:0], row_q}] <= rx_data;
  end

  assign rd_data       = rd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign tx_valid      = txv_q;
  assign tx_data       = txd_q;
  assign tx_new_matrix = txn_q;
  assign rx_ready      = (state_q == S_RECV);

endmodule
`default_nettype wire

// File: doc/mvm8_driver.md
MVM8_DRIVER -- requirements
Module: mvm8_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 12, the tx word width; result width is 2*WIDTH.
REQ-002 SHALL have parameter N, default 8, the vector length; matrix holds N*N words.
REQ-003 SHALL have parameter MAX_VEC, default 4, the maximum vectors per job.
REQ-004 One clock; reset is asynchronous and active-low; ports are named clk and reset.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- wr_en  in  1  host buffer write strobe.
- wr_addr  in  7  0..63 matrix row-major; 64..95 vectors (vec*8+i); 96..127 ignored.
- wr_data  in  WIDTH  host write data, signed.
- start  in  1  job start pulse.
- send_matrix  in  1  job includes matrix load; sampled with start.
- vec_count  in  3  vectors in job, sampled with start; values >4 clamp to 4.
- rd_addr  in  5  result index (vec*8+row).
- rd_data  out  2*WIDTH  registered result read.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- tx_valid  out  1  word offered to the MVM.
- tx_ready  in  1  MVM accepts the word.
- tx_data  out  WIDTH  word to the MVM.
- tx_new_matrix  out  1  marks the first matrix word.
- rx_valid  in  1  MVM result valid.
- rx_ready  out  1  block accepts the result.
- rx_data  in  2*WIDTH  MVM result, signed.

Function
REQ-006 SHALL contain three buffers: matrix 64xWIDTH, vector 32xWIDTH, result 32x2*WIDTH.
REQ-007 SHALL write a buffer on wr_en only when busy=0; writes with busy=1 or addr>=96 SHALL be ignored.
REQ-008 rd_data SHALL equal result[rd_addr] one cycle after rd_addr is applied, at any time.
REQ-009 FSM states SHALL be IDLE, SEND_W, SEND_X, RECV.
REQ-010 IDLE: start=1 SHALL latch send_matrix and clamped vec_count, then set busy=1 next cycle.
- Next state SEND_W if send_matrix=1.
- Else SEND_X if vec_count>0.
- Else stay in IDLE with done=1 next cycle.
REQ-011 start while busy=1 SHALL be ignored.
REQ-012 A transfer SHALL occur on a cycle with tx_valid&tx_ready.
- While tx_valid=1 and tx_ready=0, tx_data and tx_new_matrix SHALL hold.
- tx_valid SHALL not drop before the transfer.
REQ-013 SEND_W SHALL send matrix[0..63] in order; tx_new_matrix=1 only with word 0.
- After word 63 transfers: SEND_X if vec_count>0, else IDLE with done pulse.
REQ-014 SEND_X SHALL send vector[v*8+0..7] for current vector v with tx_new_matrix=0, then enter RECV.
REQ-015 RECV SHALL drive rx_ready=1.
- Each rx_valid&rx_ready SHALL store rx_data to result[v*8+row], row incrementing 0..7.
- After row 7: v+1 < vec_count goes to SEND_X; otherwise IDLE with done pulse.
REQ-016 rx_ready SHALL be 0 outside RECV; tx_valid SHALL be 0 outside SEND_W/SEND_X.
REQ-017 tx_valid SHALL be registered; the first word is offered the cycle after entering the send state.
- Back-to-back transfers SHALL sustain one word per cycle while tx_ready=1.
REQ-018 done SHALL be 1 for exactly one cycle, coinciding with busy falling to 0.
REQ-019 Word counter SHALL be 6 bits, row counter 3 bits, vector counter 3 bits; no counter wraps within a job.

Reset
REQ-020 reset=0 SHALL immediately force:
- state IDLE and all counters 0;
- tx_valid, tx_new_matrix, rx_ready, busy, done = 0;
- tx_data = 0 and rd_data = 0.
REQ-021 Buffer contents SHALL not be cleared by reset; reset mid-job SHALL abort without a done pulse.

Verification
REQ-022 Load matrix[k]=k, vector[i]=1, start send_matrix=1 vec_count=1, tx_ready=1:
- expect 72 transfers in 72 consecutive cycles;
- tx_new_matrix only on word 0 (data 0);
- then rx_ready=1.
REQ-023 Feed results 100..107 with rx_valid in alternate cycles:
- expect result[0..7]=100..107 via rd_data;
- expect done pulse after the 8th.
REQ-024 Random tx_ready stalls (50%):
- tx_data holds during stalls;
- sequence identical to the no-stall run;
- no word dropped or duplicated.
REQ-025 start send_matrix=0 vec_count=6:
- expect 4 vector/result rounds (clamped);
- results at indices 0..31;
- no new_matrix asserted.
REQ-026 reset=0 at matrix word 30:
- outputs go 0 asynchronously, no done pulse;
- a following job restarts from word 0 with tx_new_matrix=1.
REQ-027 start with send_matrix=0 vec_count=0:
- expect no tx_valid;
- done pulse one cycle after start.
